// File: rtl/core_config_pkg.sv
// Core-wide configuration constants and the per-ALU result record used by
// integration glue to pack and unpack the flattened commit buses.
package core_config_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ALU_UNITS = 4;

  typedef struct packed {
    logic [XLEN-1:0]       res;
    logic [REG_ADDR_W-1:0] rd;
    logic                  valid;
    logic                  error;
  } alu_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: picks the first set request
// at or above rr_ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_commit_arbiter.sv
// Commit stage behind the ALUs: round-robin selects one finished result per
// cycle, writes it to the register file, and pulses a clear back to its unit.
module alu_commit_arbiter
  import core_config_pkg::*;
#(
  parameter int NUM_UNITS  = NUM_ALU_UNITS,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS*XLEN-1:0]       unit_res,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0] unit_rd,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  input  logic [NUM_UNITS-1:0]            unit_error,
  output logic [NUM_UNITS-1:0]            unit_clear,
  input  logic                            wb_stall,
  output logic                            wb_we,
  output logic [REG_ADDR_W-1:0]           wb_rd,
  output logic [XLEN-1:0]                 wb_data,
  output logic                            exc_valid,
  output logic [$clog2(NUM_UNITS)-1:0]    exc_unit,
  output logic [CNT_W-1:0]                commit_cnt
);

  localparam int IDX_W = $clog2(NUM_UNITS);

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      rr_next;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [NUM_UNITS-1:0]  req;
  logic [NUM_UNITS-1:0]  grant_onehot;
  logic [XLEN-1:0]       grant_res;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic                  grant_error;

  // A unit being cleared this cycle still shows its stale valid; mask it.
  assign req = wb_stall ? '0 : (unit_valid & ~unit_clear);

  rr_arbiter #(
    .NUM_REQ (NUM_UNITS),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    grant_res    = unit_res[int'(grant_idx)*XLEN +: XLEN];
    grant_rd     = unit_rd[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
    grant_error  = unit_error[grant_idx];
    grant_onehot = NUM_UNITS'(1) << grant_idx;
    rr_next      = IDX_W'((int'(grant_idx) + 1) % NUM_UNITS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_clear <= '0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      exc_valid  <= 1'b0;
      exc_unit   <= '0;
      commit_cnt <= '0;
      rr_ptr     <= '0;
    end else if (grant_valid) begin
      unit_clear <= grant_onehot;
      commit_cnt <= commit_cnt + 1'b1;
      rr_ptr     <= rr_next;
      if (grant_error) begin
        exc_valid <= 1'b1;
        exc_unit  <= grant_idx;
        wb_we     <= 1'b0;
      end else begin
        // Writes to x0 are suppressed but the result still retires.
        exc_valid <= 1'b0;
        wb_we     <= (grant_rd != '0);
        wb_rd     <= grant_rd;
        wb_data   <= grant_res;
      end
    end else begin
      unit_clear <= '0;
      wb_we      <= 1'b0;
      exc_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_commit_arbiter.sv
// Directed bench for alu_commit_arbiter; a second instance with a 4-bit
// counter shares the stimulus to observe commit-counter wrap.
module tb_alu_commit_arbiter;

  localparam int N  = 4;
  localparam int XW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*XW-1:0] unit_res;
  logic [N*RW-1:0] unit_rd;
  logic [N-1:0]    unit_valid;
  logic [N-1:0]    unit_error;
  logic            wb_stall;

  logic [N-1:0]  unit_clear;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [XW-1:0] wb_data;
  logic          exc_valid;
  logic [1:0]    exc_unit;
  logic [31:0]   commit_cnt;

  logic [N-1:0]  clear4;
  logic          we4;
  logic [RW-1:0] rd4;
  logic [XW-1:0] data4;
  logic          excv4;
  logic [1:0]    excu4;
  logic [3:0]    cnt4;

  int compared   = 0;
  int mismatched = 0;
  int grants[N];

  alu_commit_arbiter #(.NUM_UNITS(N), .XLEN(XW), .REG_ADDR_W(RW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .unit_res(unit_res), .unit_rd(unit_rd),
    .unit_valid(unit_valid), .unit_error(unit_error), .unit_clear(unit_clear),
    .wb_stall(wb_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_unit(exc_unit), .commit_cnt(commit_cnt)
  );

  alu_commit_arbiter #(.NUM_UNITS(N), .XLEN(XW), .REG_ADDR_W(RW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .unit_res(unit_res), .unit_rd(unit_rd),
    .unit_valid(unit_valid), .unit_error(unit_error), .unit_clear(clear4),
    .wb_stall(wb_stall), .wb_we(we4), .wb_rd(rd4), .wb_data(data4),
    .exc_valid(excv4), .exc_unit(excu4), .commit_cnt(cnt4)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int unit, input logic valid, input logic error,
                               input logic [RW-1:0] rd, input logic [XW-1:0] res);
    unit_valid[unit]        = valid;
    unit_error[unit]        = error;
    unit_rd[unit*RW +: RW]  = rd;
    unit_res[unit*XW +: XW] = res;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    unit_res   = '0;
    unit_rd    = '0;
    unit_valid = '0;
    unit_error = '0;
    wb_stall   = 1'b0;
    for (int u = 0; u < N; u++) grants[u] = 0;

    #3;
    checkOutput("rst_clear", unit_clear, 0);
    checkOutput("rst_we", wb_we, 0);
    checkOutput("rst_rd", wb_rd, 0);
    checkOutput("rst_data", wb_data, 0);
    checkOutput("rst_excv", exc_valid, 0);
    checkOutput("rst_excu", exc_unit, 0);
    checkOutput("rst_cnt", commit_cnt, 0);
    checkOutput("rst_cnt4", cnt4, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single result from unit1; valid stays up through its clear cycle.
    applyStimulus(1, 1'b1, 1'b0, 5'd7, 32'h0000_00A5);
    step();
    checkOutput("single_we", wb_we, 1);
    checkOutput("single_rd", wb_rd, 7);
    checkOutput("single_data", wb_data, 32'hA5);
    checkOutput("single_clear", unit_clear, 4'b0010);
    checkOutput("single_cnt", commit_cnt, 1);
    checkOutput("single_excv", exc_valid, 0);
    step();
    checkOutput("mask_clear", unit_clear, 0);
    checkOutput("mask_we", wb_we, 0);
    checkOutput("mask_cnt", commit_cnt, 1);
    checkOutput("mask_data_hold", wb_data, 32'hA5);
    applyStimulus(1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("idle_we", wb_we, 0);
    checkOutput("idle_clear", unit_clear, 0);

    // Return rr to 0 before the fairness run.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    checkOutput("pulse_cnt", commit_cnt, 0);

    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 1'b0, RW'(i + 1), XW'(32'h100 + i));
    for (int c = 0; c < 40; c++) begin
      step();
      checkOutput("rr_clear", unit_clear, 64'd1 << (c % 4));
      checkOutput("rr_data", wb_data, 64'h100 + 64'(c % 4));
      for (int u = 0; u < N; u++) if (unit_clear[u]) grants[u]++;
    end
    for (int u = 0; u < N; u++) checkOutput("rr_share", grants[u], 10);
    checkOutput("rr_cnt", commit_cnt, 40);
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("rr_drain_we", wb_we, 0);
    checkOutput("rr_drain_clear", unit_clear, 0);

    // x0 destination retires without a write.
    applyStimulus(2, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
    step();
    checkOutput("x0_we", wb_we, 0);
    checkOutput("x0_clear", unit_clear, 4'b0100);
    checkOutput("x0_cnt", commit_cnt, 41);
    checkOutput("x0_rd", wb_rd, 0);
    checkOutput("x0_data", wb_data, 32'hFFFF_FFFF);
    applyStimulus(2, 1'b0, 1'b0, 5'd0, 32'h0);

    // Erroring result goes to the exception path.
    applyStimulus(3, 1'b1, 1'b1, 5'd5, 32'h55);
    step();
    checkOutput("err_excv", exc_valid, 1);
    checkOutput("err_excu", exc_unit, 3);
    checkOutput("err_we", wb_we, 0);
    checkOutput("err_clear", unit_clear, 4'b1000);
    checkOutput("err_cnt", commit_cnt, 42);
    checkOutput("err_rd_hold", wb_rd, 0);
    applyStimulus(3, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("err_pulse_end", exc_valid, 0);
    checkOutput("err_excu_hold", exc_unit, 3);
    checkOutput("err_clear_end", unit_clear, 0);

    // Stall holds off both pending results.
    applyStimulus(0, 1'b1, 1'b0, 5'd3, 32'h10);
    applyStimulus(2, 1'b1, 1'b0, 5'd4, 32'h20);
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("stall_clear", unit_clear, 0);
      checkOutput("stall_we", wb_we, 0);
      checkOutput("stall_cnt", commit_cnt, 42);
    end
    wb_stall = 1'b0;
    step();
    checkOutput("unstall0_clear", unit_clear, 4'b0001);
    checkOutput("unstall0_rd", wb_rd, 3);
    checkOutput("unstall0_data", wb_data, 32'h10);
    checkOutput("unstall0_cnt", commit_cnt, 43);
    applyStimulus(0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("unstall2_clear", unit_clear, 4'b0100);
    checkOutput("unstall2_rd", wb_rd, 4);
    checkOutput("unstall2_data", wb_data, 32'h20);
    checkOutput("unstall2_cnt", commit_cnt, 44);
    applyStimulus(2, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("unstall_idle_we", wb_we, 0);

    // Asynchronous reset between edges with a grant pending.
    applyStimulus(1, 1'b1, 1'b0, 5'd9, 32'h99);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_clear", unit_clear, 0);
    checkOutput("arst_we", wb_we, 0);
    checkOutput("arst_rd", wb_rd, 0);
    checkOutput("arst_data", wb_data, 0);
    checkOutput("arst_excv", exc_valid, 0);
    checkOutput("arst_excu", exc_unit, 0);
    checkOutput("arst_cnt", commit_cnt, 0);
    @(posedge clk);
    #1;
    checkOutput("arst_noclear", unit_clear, 0);
    checkOutput("arst_nowe", wb_we, 0);
    rst = 1'b0;
    applyStimulus(3, 1'b1, 1'b0, 5'd11, 32'h33);
    step();
    checkOutput("arst_rr0_clear", unit_clear, 4'b0010);
    checkOutput("arst_rr0_rd", wb_rd, 9);
    checkOutput("arst_rr0_cnt", commit_cnt, 1);
    applyStimulus(1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("arst_next_clear", unit_clear, 4'b1000);
    checkOutput("arst_next_rd", wb_rd, 11);
    checkOutput("arst_next_data", wb_data, 32'h33);
    checkOutput("arst_next_cnt", commit_cnt, 2);
    applyStimulus(3, 1'b0, 1'b0, 5'd0, 32'h0);

    // Two units alternate; 17 commits since reset wraps the 4-bit counter to 1.
    applyStimulus(0, 1'b1, 1'b0, 5'd1, 32'hA0);
    applyStimulus(1, 1'b1, 1'b0, 5'd2, 32'hB0);
    for (int c = 0; c < 15; c++) begin
      step();
      checkOutput("alt_clear", unit_clear, (c % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput("alt_cnt", commit_cnt, 64'(3 + c));
      checkOutput("alt_cnt4", cnt4, 64'((3 + c) % 16));
    end
    checkOutput("wrap_cnt", commit_cnt, 17);
    checkOutput("wrap_cnt4", cnt4, 1);
    checkOutput("wrap_clear4", clear4, 4'b0001);
    checkOutput("wrap_we4", we4, 1);
    checkOutput("wrap_rd4", rd4, 1);
    checkOutput("wrap_data4", data4, 32'hA0);
    checkOutput("wrap_excv4", excv4, 0);
    checkOutput("wrap_excu4", excu4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_commit_arbiter.md
Name: alu_commit_arbiter

Overview:
- Commit stage directly downstream of the ALU execution units.
- Collects finished results (res/rd/valid/error) from NUM_UNITS ALUs and selects one per cycle with round-robin arbitration.
- Drives a registered register-file write port and returns a one-cycle clear pulse to the granted unit, so the unit drops its result.
- Reports unit errors to the exception path and keeps a retired-result counter.

Parameters:
- NUM_UNITS, 4, number of ALUs feeding the arbiter (2..8).
- XLEN, core_config_pkg::XLEN (32), data width.
- REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), destination register index width.
- CNT_W, 32, width of the commit counter.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- unit_res  in  NUM_UNITS*XLEN  per-unit result; unit i occupies bits [i*XLEN +: XLEN].
- unit_rd  in  NUM_UNITS*REG_ADDR_W  per-unit destination register.
- unit_valid  in  NUM_UNITS  unit holds a finished result.
- unit_error  in  NUM_UNITS  result carries an error flag.
- unit_clear  out  NUM_UNITS  one-cycle pulse; unit drops its result on the next edge.
- wb_stall  in  1  register file or commit logic cannot accept a write this cycle.
- wb_we  out  1  register-file write enable.
- wb_rd  out  REG_ADDR_W  write address.
- wb_data  out  XLEN  write data.
- exc_valid  out  1  one-cycle pulse: the committed result carried an error.
- exc_unit  out  $clog2(NUM_UNITS)  index of the erroring unit.
- commit_cnt  out  CNT_W  number of results retired since reset.

Behaviour:
- Reset (rst=1, asynchronous) drives these outputs to 0:
  - unit_clear, wb_we, wb_rd, wb_data, exc_valid, exc_unit, commit_cnt.
  - The rr pointer is also 0.
  - Reset mid-operation discards any pending grant; no clear is issued for it.
- Eligibility: eligible[i] = unit_valid[i] & ~unit_clear[i].
  - A unit whose clear pulse is high this cycle is masked out. Its stale valid cannot be granted twice.
- Arbitration (combinational):
  - When wb_stall=0, grant the first eligible unit, searching upward from rr and wrapping at NUM_UNITS-1 to 0.
  - When wb_stall=1 or no unit is eligible, there is no grant.
- On a rising edge with a grant g, all of the following register:
  - unit_clear <= one-hot(g).
  - commit_cnt <= commit_cnt + 1. The counter wraps modulo 2^CNT_W.
  - rr <= (g+1) mod NUM_UNITS.
  - If unit_error[g]=1: exc_valid<=1, exc_unit<=g, wb_we<=0.
  - Otherwise: wb_we <= (unit_rd[g]!=0), wb_rd<=unit_rd[g], wb_data<=unit_res[g]. x0 is never written, but the result still retires and is still counted.
- On a rising edge with no grant:
  - unit_clear<=0, wb_we<=0, exc_valid<=0.
  - wb_rd, wb_data and exc_unit hold their values.
  - rr is unchanged.
- Latency: a result valid in cycle N with no contention appears as wb_we=1 in cycle N+1. unit_clear is high in N+1, and the unit's valid falls in N+2.
- Throughput:
  - One commit per cycle overall.
  - A single unit can commit at most once every 2 cycles, because of the clear masking.
- wb_stall is sampled every cycle. A stalled cycle grants nothing and emits no clear, and units keep their results.
- Simultaneous valids are resolved purely by rr. Starvation is impossible: every eligible unit is granted within NUM_UNITS grants.
- Unknown or X-free requirement: unit_res and unit_rd of non-granted units never affect any output.

Decomposition:
- core_config_pkg holds:
  - XLEN and REG_ADDR_W.
  - A new constant NUM_ALU_UNITS, used as the instance default.
  - A packed struct alu_result_t {res, rd, valid, error}, used by integration glue to pack and unpack the flattened buses.
- One sub-module, rr_arbiter: parameterised round-robin priority encoder.
  - Inputs: req vector and rr pointer.
  - Outputs: grant_valid and grant_idx.
  - Purely combinational.
  - The pointer register stays in alu_commit_arbiter.

Test Plan:
- Single result: unit1 valid, res=0x0000_00A5, rd=7 -> next cycle wb_we=1, wb_rd=7, wb_data=0xA5, unit_clear=0b0010, commit_cnt=1; valid dropped by the bench after the clear -> wb_we=0.
- Round-robin: all 4 units valid continuously (re-asserted 1 cycle after each clear), rr=0 -> grant order 0,1,2,3,0,...; each unit gets 25% of commits over 40 cycles, and no unit is granted in its own clear cycle.
- x0 and error:
  - unit2 rd=0, res=0xFFFF_FFFF -> wb_we=0, unit_clear=0b0100, commit_cnt increments.
  - unit3 error=1, rd=5 -> exc_valid=1 for one cycle, exc_unit=3, wb_we=0.
- Stall: units 0 and 2 valid, wb_stall=1 for 3 cycles -> no clear and no write during the stall; after release, unit0 commits first and unit2 commits the next cycle.
- Reset mid-operation: assert rst asynchronously between edges while a grant is pending -> all outputs read 0 immediately (before the next clk edge), no clear pulse follows, and rr restarts at 0.
- Counter wrap: instantiate with CNT_W=4 and commit 17 results -> commit_cnt reads 1.
